// File: rtl/sync_axis_gen.sv
// One axis of a raster timing generator: position counter, ACT/FP/SP/BP phase FSM, sync pulse.
// Optional SYNC_AXIS_FRAME_CNT_EN adds an 8-bit period counter (frame_cnt).
module sync_axis_gen #(
  parameter int ACTIVE   = 480,
  parameter int FRONT    = 10,
  parameter int SYNC     = 2,
  parameter int BACK     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          restart,
  output logic [CW-1:0] pos,
  output logic          sync_out,
  output logic          scan_on,
`ifdef SYNC_AXIS_FRAME_CNT_EN
  output logic [7:0]    frame_cnt,
`endif
  output logic          wrap
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  generate
    if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_len
      $error("sync_axis_gen: every region length must be >= 1");
    end
    if (TOTAL > (1 << CW)) begin : g_bad_cw
      $error("sync_axis_gen: TOTAL does not fit in CW bits");
    end
  endgenerate

  // Last position of each region; the FSM leaves a region when pos sits on its last slot.
  localparam logic [CW-1:0] ACT_LAST = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] FP_LAST  = CW'(ACTIVE + FRONT - 1);
  localparam logic [CW-1:0] SP_LAST  = CW'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);

  typedef enum logic [1:0] {ACT, FP, SP, BP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pos_nxt;
  logic          sync_nxt;
  logic          at_last;

  assign at_last = (pos == LAST);

  // State register (pos and sync_out move on the same edge as state)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ACT;
      pos      <= '0;
      sync_out <= ~SYNC_POL;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      sync_out <= sync_nxt;
    end
  end

  // Next-state logic; restart overrides tick
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    if (restart) begin
      state_nxt = ACT;
      pos_nxt   = '0;
    end else if (tick) begin
      pos_nxt = at_last ? '0 : pos + CW'(1);
      unique case (state)
        ACT: if (pos == ACT_LAST) state_nxt = FP;
        FP:  if (pos == FP_LAST)  state_nxt = SP;
        SP:  if (pos == SP_LAST)  state_nxt = BP;
        BP:  if (at_last)         state_nxt = ACT;
        default:                  state_nxt = ACT;
      endcase
    end
  end

  // Outputs: sync is registered from the next state so it lines up with pos
  always_comb begin
    sync_nxt = (state_nxt == SP) ? SYNC_POL : ~SYNC_POL;
    scan_on  = (state == ACT);
    wrap     = tick && !restart && at_last;
  end

`ifdef SYNC_AXIS_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     frame_cnt <= '0;
    else if (restart) frame_cnt <= '0;
    else if (wrap)    frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sync_axis_gen.sv
// Directed bench: default 480/10/2/33 axis (dut_a) and 640/16/96/48 positive-sync axis (dut_b).
module tb_sync_axis_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] pos_a, pos_b;
  logic       sync_a, sync_b, scan_a, scan_b, wrap_a, wrap_b;
`ifdef SYNC_AXIS_FRAME_CNT_EN
  logic [7:0] fc_a, fc_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_axis_gen dut_a (
    .clk(clk), .reset_n(reset_n), .tick(tick), .restart(restart),
    .pos(pos_a), .sync_out(sync_a), .scan_on(scan_a),
`ifdef SYNC_AXIS_FRAME_CNT_EN
    .frame_cnt(fc_a),
`endif
    .wrap(wrap_a)
  );

  sync_axis_gen #(.ACTIVE(640), .FRONT(16), .SYNC(96), .BACK(48), .SYNC_POL(1'b1), .CW(10)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(tick), .restart(restart),
    .pos(pos_b), .sync_out(sync_b), .scan_on(scan_b),
`ifdef SYNC_AXIS_FRAME_CNT_EN
    .frame_cnt(fc_b),
`endif
    .wrap(wrap_b)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges, return 1 time unit after the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick4();
    tick = 1'b1; cyc(1);
    tick = 1'b0; cyc(3);
  endtask

  initial begin
    int lo_cnt;

    // Reset state
    cyc(2);
    chk("rst_pos_a", pos_a, 0);
    chk("rst_sync_a", sync_a, 1);
    chk("rst_scan_a", scan_a, 1);
    chk("rst_wrap_a", wrap_a, 0);
    chk("rst_sync_b", sync_b, 0);

    // Free-running from reset, T edges after release => pos_a = T mod 525
    reset_n = 1'b1; tick = 1'b1;
    cyc(479); chk("pos_479", pos_a, 479); chk("scan_479", scan_a, 1);
    cyc(1);   chk("scan_480", scan_a, 0);
    cyc(9);   chk("sync_489", sync_a, 1);
    cyc(1);   chk("sync_490", sync_a, 0);
    cyc(1);   chk("sync_491", sync_a, 0);
    cyc(1);   chk("sync_492", sync_a, 1);
    cyc(31);  chk("wrap_523", wrap_a, 0);
    cyc(1);   chk("pos_524", pos_a, 524); chk("wrap_524", wrap_a, 1);
    cyc(1);   chk("pos_wrapped", pos_a, 0); chk("wrap_0", wrap_a, 0); chk("scan_0", scan_a, 1);

    // dut_b, 640x480-style horizontal timing, positive sync
    cyc(130); chk("b_sync_655", sync_b, 0); chk("b_pos_655", pos_b, 655);
    cyc(1);   chk("b_sync_656", sync_b, 1);
    cyc(95);  chk("b_sync_751", sync_b, 1);
    cyc(1);   chk("b_sync_752", sync_b, 0);
    cyc(47);  chk("b_wrap_799", wrap_b, 1);
    cyc(1);   chk("b_pos_800", pos_b, 0); chk("a_pos_800", pos_a, 275);

    // Restart mid-period
    cyc(25);  chk("pos_300", pos_a, 300);
    restart = 1'b1;
    #1 chk("restart_wrap_300", wrap_a, 0);
    cyc(1);   chk("restart_pos", pos_a, 0); chk("restart_scan", scan_a, 1);
    restart = 1'b0;

    // Restart coinciding with the wrap position
    cyc(524); chk("pos_524b", pos_a, 524); chk("wrap_524b", wrap_a, 1);
    restart = 1'b1;
    #1 chk("restart_wrap_524", wrap_a, 0);
    cyc(1);   chk("restart_pos_524", pos_a, 0); chk("restart_wrap_after", wrap_a, 0);
    restart = 1'b0;

    // Tick every 4th clock
    tick = 1'b0;
    cyc(3);   chk("hold_no_tick", pos_a, 0);
    for (int i = 0; i < 489; i++) tick4();
    chk("slow_pos_489", pos_a, 489); chk("slow_sync_489", sync_a, 1);
    lo_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick = (i % 4 == 0);
      cyc(1);
      if (sync_a == 1'b0) lo_cnt++;
    end
    chk("slow_sync_width", lo_cnt, 8);
    chk("slow_pos_493", pos_a, 493);

    // Asynchronous reset in the middle of the sync pulse
    restart = 1'b1; tick = 1'b1;
    cyc(1);
    restart = 1'b0;
    cyc(491); chk("pre_rst_pos", pos_a, 491); chk("pre_rst_sync", sync_a, 0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_sync", sync_a, 1);
    chk("async_rst_pos", pos_a, 0);
    chk("async_rst_scan", scan_a, 1);
    chk("async_rst_wrap", wrap_a, 0);
    cyc(2);   chk("held_rst_pos", pos_a, 0);
    reset_n = 1'b1;
    cyc(1);   chk("post_rst_pos", pos_a, 1); chk("post_rst_sync", sync_a, 1);
`ifdef SYNC_AXIS_FRAME_CNT_EN
    chk("frame_cnt_rst", fc_a, 0);
    cyc(524); chk("frame_cnt_one", fc_a, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
